// File: rtl/ppg_beat_detector_if.sv
// ppg_beat_detector_if
//   Groups the sample-stream inputs and beat/rate outputs of ppg_beat_detector.
//   Build macro: PPG_AMPLITUDE_EN adds the ac_amplitude signal.
//
//   enable        controller in operation; low forces the detector to IDLE
//   sample_valid  one-cycle strobe, new IR sample
//   sample        8-bit unsigned IR ADC value
//   beat_pulse    one-cycle pulse on every accepted peak
//   interval      last accepted beat interval, in samples
//   bpm           last computed rate, truncated quotient
//   bpm_valid     level, bpm is current
//   bpm_update    one-cycle pulse when bpm is written
//   ac_amplitude  (PPG_AMPLITUDE_EN) peak-to-trough amplitude at last beat
//
//   master: sample source / output consumer; slave: the detector.
interface ppg_beat_detector_if;
    logic       enable;
    logic       sample_valid;
    logic [7:0] sample;
    logic       beat_pulse;
    logic [7:0] interval;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       bpm_update;
`ifdef PPG_AMPLITUDE_EN
    logic [7:0] ac_amplitude;

    modport master (
        output enable, sample_valid, sample,
        input  beat_pulse, interval, bpm, bpm_valid, bpm_update, ac_amplitude
    );
    modport slave (
        input  enable, sample_valid, sample,
        output beat_pulse, interval, bpm, bpm_valid, bpm_update, ac_amplitude
    );
`else
    modport master (
        output enable, sample_valid, sample,
        input  beat_pulse, interval, bpm, bpm_valid, bpm_update
    );
    modport slave (
        input  enable, sample_valid, sample,
        output beat_pulse, interval, bpm, bpm_valid, bpm_update
    );
`endif
endinterface

// File: rtl/ppg_beat_detector.sv
// ppg_beat_detector
//   Moving-average filter on the IR sample stream, hysteretic peak/trough
//   detector, saturating beat-interval counter and a 16-step restoring divider
//   converting the interval (samples) into beats per minute.
//   Build macro: PPG_AMPLITUDE_EN enables the ac_amplitude output.
//
//   CLK    system clock
//   rst_n  asynchronous reset, active-low
//   bus    ppg_beat_detector_if.slave (enable, sample_valid, sample in;
//          beat_pulse, interval, bpm, bpm_valid, bpm_update
//          [, ac_amplitude] out)
module ppg_beat_detector #(
    parameter int unsigned SAMPLE_RATE_HZ = 50,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned HYST           = 4,
    parameter int unsigned MIN_INTERVAL   = 15,
    parameter int unsigned MAX_INTERVAL   = 150
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    ppg_beat_detector_if.slave   bus
);

    localparam int unsigned AVG_LEN   = 1 << AVG_LOG2;
    localparam int unsigned SUM_W     = 8 + AVG_LOG2;
    localparam int unsigned FILL_W    = AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(AVG_LEN - 1);
    localparam logic [15:0] DIVIDEND  = 16'(60 * SAMPLE_RATE_HZ);
    localparam logic [7:0]  CNT_MIN   = 8'(MIN_INTERVAL);
    localparam logic [7:0]  CNT_MAX   = 8'(MAX_INTERVAL);
    localparam logic [7:0]  CNT_SAT   = 8'(MAX_INTERVAL + 1);
    localparam logic [8:0]  HYST_9    = 9'(HYST);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TRACK_MAX,
        TRACK_MIN
    } state_t;

    state_t                    state_q, state_d;
    logic [AVG_LEN-1:0][7:0]   buf_q, buf_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [7:0]                filt_q, filt_d;
    logic                      filt_upd_q, filt_upd_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [7:0]                max_q, max_d;
    logic [7:0]                min_q, min_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      first_q, first_d;
    logic                      beat_q, beat_d;
    logic [7:0]                interval_q, interval_d;
    logic [7:0]                bpm_q, bpm_d;
    logic                      bpm_valid_q, bpm_valid_d;
    logic                      bpm_upd_q, bpm_upd_d;
    logic                      busy_q, busy_d;
    logic [4:0]                step_q, step_d;
    logic [7:0]                rem_q, rem_d;
    logic [15:0]               quo_q, quo_d;
    logic [8:0]                trial, diff;
    logic                      ge;
`ifdef PPG_AMPLITUDE_EN
    logic [7:0]                amp_q, amp_d;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            sum_q       <= '0;
            filt_q      <= '0;
            filt_upd_q  <= 1'b0;
            fill_q      <= '0;
            max_q       <= '0;
            min_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            beat_q      <= 1'b0;
            interval_q  <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            bpm_upd_q   <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
`ifdef PPG_AMPLITUDE_EN
            amp_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            sum_q       <= sum_d;
            filt_q      <= filt_d;
            filt_upd_q  <= filt_upd_d;
            fill_q      <= fill_d;
            max_q       <= max_d;
            min_q       <= min_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            beat_q      <= beat_d;
            interval_q  <= interval_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
            bpm_upd_q   <= bpm_upd_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
`ifdef PPG_AMPLITUDE_EN
            amp_q       <= amp_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        sum_d       = sum_q;
        filt_d      = filt_q;
        filt_upd_d  = 1'b0;
        fill_d      = fill_q;
        max_d       = max_q;
        min_d       = min_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        beat_d      = 1'b0;
        interval_d  = interval_q;
        bpm_d       = bpm_q;
        bpm_valid_d = bpm_valid_q;
        bpm_upd_d   = 1'b0;
        busy_d      = busy_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        trial       = '0;
        diff        = '0;
        ge          = 1'b0;
`ifdef PPG_AMPLITUDE_EN
        amp_d       = amp_q;
`endif

        // Filter and interval counter: both advance on the sample strobe.
        if (bus.sample_valid) begin
            sum_d    = sum_q + SUM_W'(bus.sample) - SUM_W'(buf_q[AVG_LEN-1]);
            buf_d[0] = bus.sample;
            for (int unsigned i = 1; i < AVG_LEN; i++) begin
                buf_d[i] = buf_q[i-1];
            end
            filt_d     = sum_d[SUM_W-1:AVG_LOG2];
            filt_upd_d = 1'b1;
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_MAX) begin
                    bpm_valid_d = 1'b0;
                    first_d     = 1'b1;
                end
            end
        end

        // Restoring divider: one quotient bit per clock, then one write cycle.
        if (busy_q) begin
            if (step_q != 5'd0) begin
                trial  = {rem_q, quo_q[15]};
                diff   = trial - {1'b0, interval_q};
                ge     = (trial >= {1'b0, interval_q});
                rem_d  = ge ? diff[7:0] : trial[7:0];
                quo_d  = {quo_q[14:0], ge};
                step_d = step_q - 5'd1;
            end else begin
                bpm_d       = quo_q[7:0];
                bpm_valid_d = 1'b1;
                bpm_upd_d   = 1'b1;
                busy_d      = 1'b0;
            end
        end

        // Detector: evaluated only when filt has just been refreshed.
        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                if (filt_upd_q) begin
                    if (fill_q == FILL_LAST) begin
                        max_d   = filt_q;
                        min_d   = filt_q;
                        state_d = TRACK_MAX;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
            end
            TRACK_MAX: begin
                if (filt_upd_q) begin
                    if (filt_q > max_q) begin
                        max_d = filt_q;
                    end else if (({1'b0, filt_q} + HYST_9) <= {1'b0, max_q}) begin
                        min_d   = filt_q;
                        state_d = TRACK_MIN;
                        // A saturated counter means the rhythm was lost: restart
                        // as a first beat. Short intervals are noise and leave
                        // the counter running.
                        if (first_q || cnt_q == CNT_SAT) begin
                            beat_d  = 1'b1;
                            cnt_d   = bus.sample_valid ? 8'd1 : 8'd0;
                            first_d = 1'b0;
`ifdef PPG_AMPLITUDE_EN
                            amp_d   = max_q - min_q;
`endif
                        end else if (cnt_q >= CNT_MIN) begin
                            beat_d     = 1'b1;
                            interval_d = cnt_q;
                            cnt_d      = bus.sample_valid ? 8'd1 : 8'd0;
                            busy_d     = 1'b1;
                            step_d     = 5'd16;
                            rem_d      = '0;
                            quo_d      = DIVIDEND;
`ifdef PPG_AMPLITUDE_EN
                            amp_d      = max_q - min_q;
`endif
                        end
                    end
                end
            end
            TRACK_MIN: begin
                if (filt_upd_q) begin
                    if (filt_q < min_q) begin
                        min_d = filt_q;
                    end else if ({1'b0, filt_q} >= ({1'b0, min_q} + HYST_9)) begin
                        max_d   = filt_q;
                        state_d = TRACK_MAX;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // enable low (or sitting in IDLE) overrides all of the above.
        if (!bus.enable || state_q == IDLE) begin
            state_d     = bus.enable ? FILL : IDLE;
            buf_d       = '0;
            sum_d       = '0;
            filt_d      = '0;
            filt_upd_d  = 1'b0;
            fill_d      = '0;
            cnt_d       = '0;
            first_d     = 1'b1;
            bpm_valid_d = 1'b0;
            busy_d      = 1'b0;
            step_d      = '0;
            beat_d      = 1'b0;
            bpm_upd_d   = 1'b0;
        end
    end

    assign bus.beat_pulse = beat_q;
    assign bus.interval   = interval_q;
    assign bus.bpm        = bpm_q;
    assign bus.bpm_valid  = bpm_valid_q;
    assign bus.bpm_update = bpm_upd_q;
`ifdef PPG_AMPLITUDE_EN
    assign bus.ac_amplitude = amp_q;
`endif

endmodule

// File: tb/tb_ppg_beat_detector.sv
// tb_ppg_beat_detector
//   Scoreboard bench for ppg_beat_detector. Stimulus phases push the expected
//   beat and bpm events into queues; a monitor pops and compares whenever the
//   detector presents beat_pulse or bpm_update.
//   Build macro: PPG_AMPLITUDE_EN also checks ac_amplitude on each beat.
module tb_ppg_beat_detector;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    ppg_beat_detector_if bus ();

    ppg_beat_detector #(
        .SAMPLE_RATE_HZ (50),
        .AVG_LOG2       (2),
        .HYST           (4),
        .MIN_INTERVAL   (15),
        .MAX_INTERVAL   (150)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         first;
        logic [7:0] intv;
        int         amp_min;   // 0: amplitude not checked for this beat
    } beat_t;

    beat_t      beat_q[$];
    logic [7:0] bpm_q[$];

    int errors     = 0;
    int checks     = 0;
    int cycle      = 0;
    int beats_seen = 0;
    int last_beat  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tri_val(input int n, input int p);
        int k;
        int t;
        k = n % p;
        t = (k <= p / 2) ? k : p - k;
        return 8'(100 + (160 * t) / p);
    endfunction

    task automatic send(input logic [7:0] v);
        @(negedge CLK);
        bus.sample       = v;
        bus.sample_valid = 1'b1;
        @(negedge CLK);
        bus.sample_valid = 1'b0;
        repeat (18) @(negedge CLK);
    endtask

    task automatic run_tri(input int p, input int n0, input int n1);
        for (int n = n0; n <= n1; n++) send(tri_val(n, p));
    endtask

    task automatic expect_beat(input bit first, input int intv, input int amp_min);
        beat_t b;
        b.first   = first;
        b.intv    = 8'(intv);
        b.amp_min = amp_min;
        beat_q.push_back(b);
    endtask

    task automatic phase_end(input string name);
        check({name, " pending beats"}, beat_q.size(), 0);
        check({name, " pending bpm"}, bpm_q.size(), 0);
    endtask

    task automatic restart();
        @(negedge CLK);
        bus.enable = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle bpm_valid", int'(bus.bpm_valid), 0);
        bus.enable = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " beat_pulse"}, int'(bus.beat_pulse), 0);
        check({name, " interval"},   int'(bus.interval), 0);
        check({name, " bpm"},        int'(bus.bpm), 0);
        check({name, " bpm_valid"},  int'(bus.bpm_valid), 0);
        check({name, " bpm_update"}, int'(bus.bpm_update), 0);
`ifdef PPG_AMPLITUDE_EN
        check({name, " ac_amplitude"}, int'(bus.ac_amplitude), 0);
`endif
    endtask

    // Monitor
    initial begin
        beat_t      b;
        logic [7:0] eb;
        forever begin
            @(negedge CLK);
            cycle++;
            if (rst_n) begin
                if (bus.beat_pulse) begin
                    beats_seen++;
                    last_beat = cycle;
                    if (beat_q.size() == 0) begin
                        check("spurious beat_pulse", int'(bus.beat_pulse), 0);
                    end else begin
                        b = beat_q.pop_front();
                        if (b.first)
                            check("first beat bpm_valid", int'(bus.bpm_valid), 0);
                        else
                            check("beat interval", int'(bus.interval), int'(b.intv));
`ifdef PPG_AMPLITUDE_EN
                        if (b.amp_min != 0) begin
                            checks++;
                            if (int'(bus.ac_amplitude) < b.amp_min || bus.ac_amplitude > 8'd80) begin
                                errors++;
                                $display("FAIL ac_amplitude: actual=%0d required=%0d..80",
                                         bus.ac_amplitude, b.amp_min);
                            end
                        end
`endif
                    end
                end
                if (bus.bpm_update) begin
                    if (bpm_q.size() == 0) begin
                        check("spurious bpm_update", int'(bus.bpm_update), 0);
                    end else begin
                        eb = bpm_q.pop_front();
                        check("bpm value", int'(bus.bpm), int'(eb));
                        check("bpm_valid at update", int'(bus.bpm_valid), 1);
                        check("bpm latency", cycle - last_beat, 17);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int base;
        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = 8'd0;
        rst_n            = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge CLK);
        bus.enable = 1'b1;
        repeat (3) @(negedge CLK);

        // Period 50: first beat alone, then 3000/50 = 60 bpm.
        expect_beat(1'b1, 0, 72);
        expect_beat(1'b0, 50, 72); bpm_q.push_back(8'd60);
        expect_beat(1'b0, 50, 72); bpm_q.push_back(8'd60);
        run_tri(50, 0, 149);
        phase_end("p50");
        check("p50 bpm_valid", int'(bus.bpm_valid), 1);
        check("p50 interval", int'(bus.interval), 50);

        // enable drop: bpm_valid clears, bpm and interval hold.
        @(negedge CLK);
        bus.enable = 1'b0;
        repeat (5) @(negedge CLK);
        check("disable bpm_valid", int'(bus.bpm_valid), 0);
        check("disable bpm hold", int'(bus.bpm), 60);
        check("disable interval hold", int'(bus.interval), 50);
        bus.enable = 1'b1;
        repeat (3) @(negedge CLK);

        // Period 30: 100 bpm.
        expect_beat(1'b1, 0, 0);
        expect_beat(1'b0, 30, 0); bpm_q.push_back(8'd100);
        expect_beat(1'b0, 30, 0); bpm_q.push_back(8'd100);
        run_tri(30, 0, 89);
        phase_end("p30");

        // Period 40: 75 bpm, then constant noisy input until the counter saturates.
        restart();
        expect_beat(1'b1, 0, 0);
        expect_beat(1'b0, 40, 0); bpm_q.push_back(8'd75);
        expect_beat(1'b0, 40, 0); bpm_q.push_back(8'd75);
        expect_beat(1'b0, 40, 0); bpm_q.push_back(8'd75);
        run_tri(40, 0, 159);
        phase_end("p40");
        check("p40 bpm_valid", int'(bus.bpm_valid), 1);
        for (int i = 0; i < 160; i++) send((i % 2 == 0) ? 8'd142 : 8'd138);
        check("noise bpm_valid", int'(bus.bpm_valid), 0);
        check("noise bpm hold", int'(bus.bpm), 75);
        phase_end("noise");

        // After saturation the next peak restarts as a first beat.
        expect_beat(1'b1, 0, 0);
        expect_beat(1'b0, 50, 72); bpm_q.push_back(8'd60);
        run_tri(50, 13, 112);
        phase_end("resync");

        // Period 10: second candidate is a 10-sample interval and is rejected.
        restart();
        expect_beat(1'b1, 0, 0);
        run_tri(10, 0, 22);
        phase_end("p10");
        check("p10 bpm_valid", int'(bus.bpm_valid), 0);
        check("p10 interval hold", int'(bus.interval), 50);

        // Reset five cycles into a division: no bpm_update afterwards.
        restart();
        expect_beat(1'b1, 0, 72);
        expect_beat(1'b0, 50, 72);
        base = beats_seen;
        fork
            run_tri(50, 0, 85);
            begin
                int w;
                w = 0;
                while (beats_seen < base + 2 && w < 4000) begin
                    @(negedge CLK);
                    w++;
                end
                check("reset phase beat wait", int'(beats_seen >= base + 2), 1);
                if (beats_seen >= base + 2) begin
                    repeat (5) @(negedge CLK);
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("mid-division reset");
                end
            end
        join
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (40) @(negedge CLK);
        check("post-reset bpm", int'(bus.bpm), 0);
        check("post-reset bpm_valid", int'(bus.bpm_valid), 0);
        phase_end("reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
